// File: rtl/mcp_mem_pkg.sv
// rtl/mcp_mem_pkg.sv - shared size encodings, store FSM states and byte masks
// Purpose: common definitions for the store alignment path.
// Ports: none (package).
package mcp_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;  // 2'd3 is also treated as word

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } store_state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = MASK_BYTE;
      SIZE_HALF: size_mask = MASK_HALF;
      default:   size_mask = MASK_WORD;
    endcase
  endfunction

  // A store splits when its bytes run past lane 3 of the addressed word.
  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: needs_split = 1'b0;
      SIZE_HALF: needs_split = (off == 2'd3);
      default:   needs_split = (off != 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// rtl/store_lane_shift.sv - moves store mask/data onto memory byte lanes
// Purpose: combinational lane placement for the low or high word of a store.
// Ports:
//   mask  - right-justified byte mask of the store size
//   data  - right-justified store data
//   off   - byte offset within the word
//   hi    - 1 selects the spill-over (second) word of a split store
//   be    - byte enables for the selected word
//   wdata - lane-aligned write data for the selected word
module store_lane_shift
  import mcp_mem_pkg::*;
(
  input  logic [3:0]  mask,
  input  logic [31:0] data,
  input  logic [1:0]  off,
  input  logic        hi,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  // Byte distance from the store start to the next word boundary.
  logic [2:0] hi_sh;

  always_comb begin
    hi_sh = 3'd4 - {1'b0, off};
    if (hi) begin
      be    = mask >> hi_sh;
      wdata = data >> {hi_sh, 3'b000};
    end else begin
      be    = mask << off;
      wdata = data << {off, 3'b000};
    end
  end

endmodule

// File: rtl/mem_store_align.sv
// rtl/mem_store_align.sv - aligns byte/half/word stores onto a word-wide memory
// Purpose: accepts one store, issues one or two lane-aligned word writes.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   req_valid/req_ready             - store request handshake
//   req_addr, req_data, req_size    - byte address, right-justified data, size
//   mem_we, mem_addr, mem_wdata,
//   mem_be, mem_ack                 - word write port, held until mem_ack
//   done                            - pulse after the final write is acked
//   err                             - pulse when a misaligned store is rejected
module mem_store_align
  import mcp_mem_pkg::*;
#(
  parameter int SPLIT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  store_state_t state, state_nxt;
  logic [31:0]  addr_q, data_q;
  logic [1:0]   size_q;
  logic         done_nxt, err_nxt;
  logic         split_q;
  logic [31:0]  lo_addr;
  logic [3:0]   lane_be;
  logic [31:0]  lane_wdata;

  assign split_q = needs_split(size_q, addr_q[1:0]);
  assign lo_addr = {addr_q[31:2], 2'b00};

  store_lane_shift u_lane (
    .mask  (size_mask(size_q)),
    .data  (data_q),
    .off   (addr_q[1:0]),
    .hi    (state == ST_WR_HI),
    .be    (lane_be),
    .wdata (lane_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      size_q <= 2'd0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= req_size;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Rejected stores are consumed here and never reach the write port.
          if ((SPLIT_EN == 0) && needs_split(req_size, req_addr[1:0])) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = ST_WR_LO;
          end
        end
      end
      ST_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = lo_addr;
        mem_be    = lane_be;
        mem_wdata = lane_wdata;
        if (mem_ack) begin
          if (split_q) begin
            state_nxt = ST_WR_HI;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      ST_WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = lo_addr + 32'd4;  // wraps past 0xFFFFFFFC
        mem_be    = lane_be;
        mem_wdata = lane_wdata;
        if (mem_ack) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_store_align.sv
// tb/tb_mem_store_align.sv - self-checking bench for mem_store_align
module tb_mem_store_align;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_b = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        mem_ack = 1'b0;

  logic        req_ready, mem_we, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        req_ready_b, mem_we_b, done_b, err_b;
  logic [31:0] mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_be_b;

  int n_checks = 0;
  int n_fail = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  always #5 clk = ~clk;

  mem_store_align #(.SPLIT_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .done(done), .err(err)
  );

  mem_store_align #(.SPLIT_EN(0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
    .mem_ack(mem_ack), .done(done_b), .err(err_b)
  );

  // Drive one request for one cycle and push the expected writes.
  // The model views the store as a 64-bit window spanning two words.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    logic [3:0]  m;
    logic [63:0] wide;
    logic [7:0]  be8;
    logic [31:0] base;
    wr_t w;
    m    = (s == 2'd0) ? 4'b0001 : (s == 2'd1) ? 4'b0011 : 4'b1111;
    wide = {32'd0, d} << (8 * a[1:0]);
    be8  = {4'd0, m} << a[1:0];
    base = a & 32'hFFFF_FFFC;
    w.addr = base; w.be = be8[3:0]; w.wdata = wide[31:0];
    exp_q.push_back(w);
    if (be8[7:4] != 4'd0) begin
      w.addr = base + 32'd4; w.be = be8[7:4]; w.wdata = wide[63:32];
      exp_q.push_back(w);
    end
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Act as the memory: ack each write after 'stall' wait cycles, record writes.
  task automatic collect(input int stall, output int done_at, output bit stable, output bit rdy_low);
    int  wait_n;
    wr_t snap;
    done_at = -1; stable = 1'b1; rdy_low = 1'b1; wait_n = 0; snap = '0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        done_at = c;
        break;
      end
      if (mem_we) begin
        if (req_ready) rdy_low = 1'b0;
        if (wait_n == 0) snap = {mem_addr, mem_be, mem_wdata};
        else if ({mem_addr, mem_be, mem_wdata} !== snap) stable = 1'b0;
        if (wait_n >= stall) begin
          mem_ack = 1'b1; obs_q.push_back(snap); wait_n = 0;
        end else begin
          mem_ack = 1'b0; wait_n++;
        end
      end else begin
        mem_ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata, done, err, req_ready} !== {1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_during: we=%b be=%b addr=%h wdata=%h done=%b err=%b rdy=%b, required 0/0/0/0/0/0/1",
               mem_we, mem_be, mem_addr, mem_wdata, done, err, req_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata, done, err, req_ready} !== {1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_after: we=%b be=%b addr=%h wdata=%h done=%b err=%b rdy=%b, required 0/0/0/0/0/0/1",
               mem_we, mem_be, mem_addr, mem_wdata, done, err, req_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] t_addr[5] = '{32'h0000_1003, 32'h0000_2003, 32'h0000_3002, 32'hFFFF_FFFE, 32'h0000_5000};
    logic [31:0] t_data[5] = '{32'hAABB_CCDD, 32'h0000_BEEF, 32'h1122_3344, 32'hCAFE_F00D, 32'h8765_4321};
    logic [1:0]  t_size[5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    int          t_stall[5] = '{0, 0, 3, 0, 1};
    int  n_exp, done_at;
    bit  stable, rdy_low;
    wr_t e, o;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL dir%0d_ready: got %b, required 1", i, req_ready);
      end
      issue(t_addr[i], t_data[i], t_size[i]);
      n_exp = exp_q.size();
      collect(t_stall[i], done_at, stable, rdy_low);
      n_checks++;
      if (done_at != n_exp * (t_stall[i] + 1)) begin
        n_fail++;
        $display("FAIL dir%0d_done_cycle: got %0d, required %0d", i, done_at, n_exp * (t_stall[i] + 1));
      end
      n_checks++;
      if (!stable || !rdy_low) begin
        n_fail++;
        $display("FAIL dir%0d_stall: stable=%b ready_low=%b, required 1/1", i, stable, rdy_low);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL dir%0d_write: got addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
                   i, o.addr, o.be, o.wdata, e.addr, e.be, e.wdata);
        end
      end
      n_checks++;
      if (obs_q.size() != 0) begin
        n_fail++;
        $display("FAIL dir%0d_extra_writes: got %0d, required 0", i, obs_q.size());
        obs_q.delete();
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_pulse: done=%b we=%b, required 0/0", i, done, mem_we);
      end
    end
  endtask

  task automatic test_sweep();
    int  n_exp, done_at;
    bit  stable, rdy_low;
    wr_t e, o;
    for (int s = 0; s < 4; s++) begin
      for (int off = 0; off < 4; off++) begin
        issue(32'h4000_0000 + 32'(s * 256) + 32'(off), $urandom, 2'(s));
        n_exp = exp_q.size();
        collect(0, done_at, stable, rdy_low);
        n_checks++;
        if (done_at != n_exp) begin
          n_fail++;
          $display("FAIL sweep_s%0d_o%0d_latency: got %0d, required %0d", s, off, done_at, n_exp);
        end
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
          n_checks++;
          if (o !== e) begin
            n_fail++;
            $display("FAIL sweep_s%0d_o%0d_write: got addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
                     s, off, o.addr, o.be, o.wdata, e.addr, e.be, e.wdata);
          end
        end
        obs_q.delete();
      end
    end
  endtask

  task automatic test_ack_idle();
    int  done_at;
    bit  stable, rdy_low;
    wr_t e, o;
    mem_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_idle: we=%b done=%b, required 0/0", mem_we, done);
      end
    end
    issue(32'h0000_6002, 32'h0000_A5A5, 2'd1);
    collect(0, done_at, stable, rdy_low);
    n_checks++;
    if (done_at != 1) begin
      n_fail++;
      $display("FAIL ack_high_latency: got %0d, required 1", done_at);
    end
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL ack_high_write: got addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
               o.addr, o.be, o.wdata, e.addr, e.be, e.wdata);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int  done_at;
    bit  stable, rdy_low;
    wr_t e, o;
    issue(32'h0000_7001, 32'hDEAD_BEEF, 2'd2);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h0000_7004) begin
      n_fail++;
      $display("FAIL rst_mid_in_hi: we=%b addr=%h, required 1/00007004", mem_we, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_be !== 4'd0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_async: we=%b be=%b rdy=%b, required 0/0000/1", mem_we, mem_be, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet: we=%b done=%b, required 0/0", mem_we, done);
      end
    end
    issue(32'h0000_8000, 32'h0102_0304, 2'd2);
    collect(0, done_at, stable, rdy_low);
    e = exp_q.pop_front();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
    n_checks++;
    if (o !== e || done_at != 1) begin
      n_fail++;
      $display("FAIL rst_mid_next: got addr=%h be=%b wdata=%h done_at=%0d, required addr=%h be=%b wdata=%h done_at=1",
               o.addr, o.be, o.wdata, done_at, e.addr, e.be, e.wdata);
    end
    obs_q.delete();
  endtask

  task automatic test_no_split();
    n_checks++;
    if (req_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL nosplit_ready: got %b, required 1", req_ready_b);
    end
    req_valid_b = 1'b1; req_addr = 32'h0000_0001; req_data = 32'h1234_5678; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    n_checks++;
    if ({err_b, mem_we_b, done_b} !== 3'b100) begin
      n_fail++;
      $display("FAIL nosplit_err: err=%b we=%b done=%b, required 1/0/0", err_b, mem_we_b, done_b);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({err_b, mem_we_b, done_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL nosplit_err_pulse: err=%b we=%b done=%b, required 0/0/0", err_b, mem_we_b, done_b);
    end
    req_valid_b = 1'b1; req_addr = 32'h0000_0008; req_data = 32'h9ABC_DEF0; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    n_checks++;
    if ({mem_we_b, mem_addr_b, mem_be_b, mem_wdata_b} !== {1'b1, 32'h0000_0008, 4'b1111, 32'h9ABC_DEF0}) begin
      n_fail++;
      $display("FAIL nosplit_aligned: we=%b addr=%h be=%b wdata=%h, required 1/00000008/1111/9abcdef0",
               mem_we_b, mem_addr_b, mem_be_b, mem_wdata_b);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++;
    if ({done_b, err_b, mem_we_b} !== 3'b100) begin
      n_fail++;
      $display("FAIL nosplit_done: done=%b err=%b we=%b, required 1/0/0", done_b, err_b, mem_we_b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sweep();
    test_ack_idle();
    test_reset_mid();
    test_no_split();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
